// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing the 2-in/2-out LED mux between requesters A and B.
// A grant holds the mux for a fixed dwell (or until the owner withdraws), followed
// by a one-cycle RELEASE that pulses done. The select lines hold their last value
// through RELEASE and IDLE so the LEDs never glitch between grants.
module mux_arbiter #(
    parameter int HOLD_CYCLES = 8,
    parameter int CW          = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic dst_a,
    input  logic req_b,
    input  logic dst_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sw1_,
    output logic sw2_,
    output logic st_ps,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Terminal count; HOLD_CYCLES <= 2**CW keeps this within cnt's range.
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_b;     // 1 = B owned the last grant, so A wins a tie
    logic          owner_req;
    logic          win_a;
    logic          win_b;

    // Tie goes to whoever did not own the previous grant; owner's request is tracked for aborts.
    always_comb begin
        win_a     = req_a & (~req_b | last_b);
        win_b     = req_b & (~req_a | ~last_b);
        owner_req = gnt_a ? req_a : req_b;
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            sw1_   <= 1'b0;
            sw2_   <= 1'b0;
            st_ps  <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            last_b <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    cnt  <= '0;
                    if (win_a) begin
                        state  <= HOLD;
                        gnt_a  <= 1'b1;
                        gnt_b  <= 1'b0;
                        sw1_   <= 1'b1;
                        sw2_   <= dst_a;
                        st_ps  <= 1'b1;
                        last_b <= 1'b0;
                    end else if (win_b) begin
                        state  <= HOLD;
                        gnt_a  <= 1'b0;
                        gnt_b  <= 1'b1;
                        sw1_   <= 1'b0;
                        sw2_   <= dst_b;
                        st_ps  <= 1'b1;
                        last_b <= 1'b1;
                    end else begin
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b0;
                        st_ps <= 1'b0;
                    end
                end
                HOLD: begin
                    // Exit check comes before the increment so cnt never wraps.
                    if (!owner_req || cnt == CNT_LAST) begin
                        state <= RELEASE;
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b0;
                        st_ps <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    gnt_a  <= 1'b0;
                    gnt_b  <= 1'b0;
                    sw1_   <= 1'b0;
                    sw2_   <= 1'b0;
                    st_ps  <= 1'b0;
                    done   <= 1'b0;
                    cnt    <= '0;
                    last_b <= 1'b1;
                end
            endcase
        end
    end

endmodule
